// File: rtl/grey_counter_pkg.sv
// Shared Gray-code helpers for the grey_counter slice: encoder, Hamming distance
// and the per-edge request type.
package GreyPkg;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_INC,
        REQ_LOAD,
        REQ_CLR,
        REQ_RST
    } req_e;

    function automatic logic [31:0] grey_enc(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic int unsigned grey_dist(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]  diff;
        int unsigned  cnt;
        diff = a ^ b;
        cnt  = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            cnt += int'(diff[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/grey_counter_encode.sv
// WIDTH-generic combinational binary-to-Gray converter, plus the elaboration
// trap module instantiated for an illegal counter width.
module GreyEncode
    import GreyPkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] grey
);

    assign grey = WIDTH'(grey_enc(32'(bin)));

endmodule

module PanicModule ();
endmodule

// File: rtl/grey_counter.sv
// Registered Gray-code counter for CDC pointer use. Optional Gray-step checker
// driving err_o is enabled by defining GREY_COUNTER_CHECK_EN.
module grey_counter
    import GreyPkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] grey_o,
    output logic [WIDTH-1:0] grey_next_o,
    output logic             wrap_o,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GREY = WIDTH'(grey_enc(32'(RST_BIN)));

    if (WIDTH < 1 || WIDTH > 32) begin : g_panic
        PanicModule u_panic ();
    end

    req_e             req;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] grey_q;
    logic [WIDTH-1:0] grey_next;
    logic             wrap_q;

    always_comb begin
        req = REQ_NONE;
        if (rst_i)       req = REQ_RST;
        else if (clr_i)  req = REQ_CLR;
        else if (load_i) req = REQ_LOAD;
        else if (inc_i)  req = REQ_INC;
    end

    always_comb begin
        bin_next = bin_q;
        case (req)
            REQ_RST,
            REQ_CLR:  bin_next = RST_BIN;
            REQ_LOAD: bin_next = load_val_i;
            REQ_INC:  bin_next = bin_q + WIDTH'(1);
            default:  bin_next = bin_q;
        endcase
    end

    // Gray register is fed from the next binary value, never from bin_q.
    GreyEncode #(.WIDTH(WIDTH)) u_enc (
        .bin  (bin_next),
        .grey (grey_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= RST_BIN;
            grey_q <= RST_GREY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            grey_q <= grey_next;
            wrap_q <= (req == REQ_INC) && (bin_q == '1);
        end
    end

`ifdef GREY_COUNTER_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             inc_only_q;
    logic             err_q;

    // inc_only_q marks that the edge producing the current grey_q was a pure increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= RST_GREY;
            inc_only_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= grey_q;
            inc_only_q <= (req == REQ_INC);
            if (inc_only_q && (grey_q != prev_q) &&
                (grey_dist(32'(grey_q), 32'(prev_q)) != 32'd1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bin_o       = bin_q;
    assign grey_o      = grey_q;
    assign grey_next_o = grey_next;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_grey_counter.sv
// Self-checking bench for grey_counter (WIDTH=4, RESET_VAL=0): directed vector
// table, fault-injection sequence for the Gray checker, and randomized run vs. a model.
module tb_grey_counter;

    localparam int W  = 4;
    localparam int RV = 0;
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         inc = 1'b0;
    logic [W-1:0] bin_o, grey_o, grey_next_o;
    logic         wrap_o, err_o;

    int n_chk  = 0;
    int n_fail = 0;

    int           m_bin = RV;
    logic [W-1:0] gn_s;

    always #5 clk = ~clk;

    grey_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .load_i      (load),
        .load_val_i  (load_val),
        .inc_i       (inc),
        .bin_o       (bin_o),
        .grey_o      (grey_o),
        .grey_next_o (grey_next_o),
        .wrap_o      (wrap_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic         rst, clr, load;
        logic [W-1:0] val;
        logic         inc;
        logic [W-1:0] bin, grey;
        logic         wrap;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] gseq [0:16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs one ns after an edge, sample grey_next_o, then advance past the next edge.
    task automatic drive(input logic r, input logic c, input logic l,
                         input logic [W-1:0] v, input logic i);
        rst = r; clr = c; load = l; load_val = v; inc = i;
        #1;
        gn_s = grey_next_o;
        @(posedge clk);
        #1;
    endtask

    task automatic model_next(input logic r, input logic c, input logic l,
                              input logic [W-1:0] v, input logic i,
                              output int nb, output logic nw);
        nw = 1'b0;
        if (r || c)   nb = RV;
        else if (l)   nb = int'(v);
        else if (i) begin
            nb = (m_bin + 1) % M;
            nw = (m_bin == M - 1);
        end else      nb = m_bin;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           nb;
        logic         nw;
        logic         exp_err;
        logic [W-1:0] prev_g;
        logic         r, c, l, i;
        logic [W-1:0] v;

        // Directed table: reset, full wrap, priority corners.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, gseq[0], 1'b0});
        for (int k = 1; k <= 16; k++)
            vecs.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'(k % 16), gseq[k], (k == 16)});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 4'b1010, 4'b1111, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1011, 4'b1110, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 4'b0111, 4'b0100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 4'b1001, 4'b1101, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1111, 4'b1000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0});

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].clr, vecs[k].load, vecs[k].val, vecs[k].inc);
            if (k > 0) chk($sformatf("tbl%0d grey_next", k), 32'(gn_s), 32'(vecs[k].grey));
            chk($sformatf("tbl%0d bin", k),  32'(bin_o),  32'(vecs[k].bin));
            chk($sformatf("tbl%0d grey", k), 32'(grey_o), 32'(vecs[k].grey));
            chk($sformatf("tbl%0d wrap", k), 32'(wrap_o), 32'(vecs[k].wrap));
            chk($sformatf("tbl%0d err", k),  32'(err_o),  32'd0);
        end
        m_bin = 0;

        // Fault injection: corrupt the Gray register right after an increment.
`ifdef GREY_COUNTER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
        chk("inj pre grey", 32'(grey_o), 32'b0001);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        force dut.grey_q = 4'b0010;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        release dut.grey_q;
        chk("inj err set", 32'(err_o), 32'(exp_err));
        drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("inj err held over clr", 32'(err_o), 32'(exp_err));
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("inj err held", 32'(err_o), 32'(exp_err));
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("inj err cleared by rst", 32'(err_o), 32'd0);
        chk("inj bin after rst", 32'(bin_o), 32'(RV));
        m_bin = RV;

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 5) == 0);
            i = ($urandom_range(0, 1) == 1);
            v = W'($urandom);
            model_next(r, c, l, v, i, nb, nw);
            prev_g = grey_o;
            drive(r, c, l, v, i);
            chk($sformatf("rnd%0d grey_next", n), 32'(gn_s), 32'(gray(nb)));
            chk($sformatf("rnd%0d bin", n),  32'(bin_o),  32'(nb));
            chk($sformatf("rnd%0d grey", n), 32'(grey_o), 32'(gray(nb)));
            chk($sformatf("rnd%0d wrap", n), 32'(wrap_o), 32'(nw));
            chk($sformatf("rnd%0d err", n),  32'(err_o),  32'd0);
            if (!r && !c && !l && i)
                chk($sformatf("rnd%0d step", n), 32'($countones(prev_g ^ grey_o)), 32'd1);
            m_bin = nb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
